keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Matrix scanner for the 4x4 keypad of the keyboard interface. It sits directly upstream of the bounce-elimination stage. It drives one column low at a time, samples the active-low row lines, and encodes the first closed contact found as a 4-bit key code. Its `key_pressed` output feeds the bounce stage's key-pressed input; that stage's `inhibit` output comes back here to freeze the scanner until the key is released.

## Interface
- `SETTLE_CYCLES`, default 2700: clocks each column is driven before rows are sampled (100 µs at 27 MHz). Must be ≥ 4.
- `clk` in 1: system clock (27 MHz board clock).
- `rst` in 1: asynchronous, active-high reset.
- `row_n` in 4: raw keypad rows, active-low (external pull-ups), asynchronous to `clk`.
- `inhibit` in 1: from the bounce stage; 1 = key still held, do not resume scanning.
- `col_n` out 4: column drive, one-hot-low; exactly one bit is 0 at all times.
- `key_pressed` out 1: 1 while the captured key is closed.
- `key_code` out 4: `{row[1:0], col[1:0]}` of the last captured key, i.e. code = row*4 + col.

## Operation
- **Reset values:** `col_n`=4'b1110 (column 0), `key_pressed`=0, `key_code`=0, state SETTLE, settle counter=0, column index=0.
- **Row conditioning:** `row_n` passes through the row synchronizer (see Configuration) to give `row_s`.
- **State SETTLE**
  - Drive column index `c`.
  - The settle counter counts 0..SETTLE_CYCLES-1.
  - On count SETTLE_CYCLES-1, go to SAMPLE and clear the counter.
- **State SAMPLE** (one cycle)
  - If `row_s` != 4'b1111: lowest-index low row `r` wins.
  - In that case, register `key_code`={r,c} and `key_pressed`=1, latch `r`, and go to HOLD with the column unchanged.
  - Otherwise, `c` = c+1 mod 4 (3 wraps to 0) and return to SETTLE.
- **State HOLD**
  - Column stays driven.
  - `key_pressed` = registered NOT `row_s[r]`, so it follows the captured contact, including bounce.
  - Exit to SETTLE with `c`+1 only when `row_s[r]`=1 and `inhibit`=0 in the same cycle.
  - While `inhibit`=1, remain in HOLD even if the row is released; `key_pressed` reads 0 in that case.
  - Other keys pressed during HOLD are ignored.
- **Multiple keys:** within one column, the lowest row wins. Across columns, the first column scanned wins.
- **`key_code`** changes only in SAMPLE on a hit. It holds its value after release and is cleared only by `rst`.
- **`inhibit` outside HOLD:** freezes the settle counter and column index (scan pauses) until it drops.
- **Reset mid-operation:** returns immediately to reset values regardless of state.
- **Counter width:** $clog2(SETTLE_CYCLES). No overflow is possible because the counter is cleared at the terminal count.

## Timing
- One column period is SETTLE_CYCLES+1 clocks; a full idle scan is 4*(SETTLE_CYCLES+1).
- `row_s` latency from `row_n`: 2 clocks with the macro defined, 1 clock without.
- `key_pressed` and `key_code` are updated on the clock edge ending SAMPLE. They are visible in the cycle after SAMPLE.
- **Release in HOLD:** `key_pressed` falls (row_s latency + 1) clocks after `row_n[r]` rises.
- **Leaving HOLD:** `col_n` advances on the edge after the exit condition. The settle counter restarts at 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- **`KEYSCAN_SYNC_EN` defined:** `row_n` passes through a 2-flop synchronizer per bit.
- **`KEYSCAN_SYNC_EN` undefined:** a single register stage is used (for simulation or pre-synchronized rows).
- All state-machine behaviour is identical in both builds; only the latency figures above change.

## Test plan
All scenarios use SETTLE_CYCLES=8 and `KEYSCAN_SYNC_EN` defined.
1. **Reset:** assert `rst` mid-scan → `col_n`=1110, `key_pressed`=0, `key_code`=0 immediately (asynchronous).
2. **Idle scan:** `row_n`=1111, `inhibit`=0 → `col_n` steps 1110→1101→1011→0111→1110, one step every 9 clocks. `key_pressed` stays 0.
3. **Single key:** hold `row_n`=1011 (row 2) when `col_n`=1101 (col 1) → `key_pressed`=1, `key_code`=4'd9. `col_n` holds 1101.
4. **Release, no inhibit:** from scenario 3, `row_n`=1111 with `inhibit`=0 → `key_pressed`=0 3 clocks later. `col_n`=1011 on the next edge. `key_code` stays 9.
5. **Release under inhibit:** from scenario 3, release with `inhibit`=1 for 20 clocks → `key_pressed`=0 and `col_n` stays 1101 throughout. When `inhibit` drops, `col_n` advances to 1011.
6. **Two keys, one column:** `row_n`=0101 (rows 1 and 3) during col 0 → `key_code`=4'd4.

Source files
------------

// File: rtl/keypad_scanner.sv
`timescale 1ns/1ps
// keypad_scanner
// Scans a 4x4 matrix keypad. It drives one column low at a time and samples
// the active-low rows after a settling delay. It captures the first closed
// contact as key_code = {row, col}. It then holds that column while the
// bounce stage asserts inhibit.
//
// Build option: define KEYSCAN_SYNC_EN to pass row_n through a 2-flop
// synchronizer (2-clock row latency). Without it, a single register stage
// is used (1-clock row latency). State-machine behaviour is identical.
module keypad_scanner #(
    parameter int SETTLE_CYCLES = 2700
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    input  logic       inhibit,
    output logic [3:0] col_n,
    output logic       key_pressed,
    output logic [3:0] key_code
);

    localparam int              CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    localparam logic [1:0] ST_SETTLE = 2'd0;
    localparam logic [1:0] ST_SAMPLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] settle_cnt;
    logic [1:0]       col_idx;
    logic [1:0]       held_row;
    logic [3:0]       row_s;
    logic             hit;
    logic [1:0]       hit_row;

    // ---- row conditioning stage ----
`ifdef KEYSCAN_SYNC_EN
    logic [3:0] row_p0;
    logic [3:0] row_p1;

    // Two-flop synchronizer; idles released so a sample right after reset sees no key.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_p0 <= 4'hF;
            row_p1 <= 4'hF;
        end else begin
            row_p0 <= row_n;
            row_p1 <= row_p0;
        end
    end

    assign row_s = row_p1;
`else
    logic [3:0] row_p0;

    // Single register stage for rows that are already synchronous to clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_p0 <= 4'hF;
        end else begin
            row_p0 <= row_n;
        end
    end

    assign row_s = row_p0;
`endif

    // ---- scan control stage ----
    // Priority encoder: the lowest-index low row wins within the driven column.
    always_comb begin
        hit     = 1'b0;
        hit_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!row_s[i]) begin
                hit     = 1'b1;
                hit_row = 2'(i);
            end
        end
    end

    // Scan FSM. col_n is kept as its own rotating register, so the pins come straight off flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_SETTLE;
            settle_cnt  <= '0;
            col_idx     <= 2'd0;
            col_n       <= 4'b1110;
            held_row    <= 2'd0;
            key_pressed <= 1'b0;
            key_code    <= 4'd0;
        end else begin
            case (state)
                ST_SETTLE: begin
                    key_pressed <= 1'b0;
                    // inhibit outside HOLD pauses the scan where it stands
                    if (!inhibit) begin
                        if (settle_cnt == CNT_LAST) begin
                            settle_cnt <= '0;
                            state      <= ST_SAMPLE;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                end

                ST_SAMPLE: begin
                    if (!inhibit) begin
                        if (hit) begin
                            key_code    <= {hit_row, col_idx};
                            key_pressed <= 1'b1;
                            held_row    <= hit_row;
                            state       <= ST_HOLD;
                        end else begin
                            col_idx <= col_idx + 1'b1;
                            col_n   <= {col_n[2:0], col_n[3]};
                            state   <= ST_SETTLE;
                        end
                    end
                end

                ST_HOLD: begin
                    // follow only the captured contact; other keys are ignored
                    key_pressed <= ~row_s[held_row];
                    if (row_s[held_row] && !inhibit) begin
                        col_idx    <= col_idx + 1'b1;
                        col_n      <= {col_n[2:0], col_n[3]};
                        settle_cnt <= '0;
                        state      <= ST_SETTLE;
                    end
                end

                default: begin
                    state      <= ST_SETTLE;
                    settle_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
`timescale 1ns/1ps
// Self-checking bench for keypad_scanner with a behavioural 4x4 keypad.
module tb_keypad_scanner;

    localparam int SETTLE      = 8;
    localparam int PERIOD_CLKS = SETTLE + 1;
`ifdef KEYSCAN_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        inhibit;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic        key_pressed;
    logic [3:0]  key_code;
    logic [15:0] pressed;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [3:0] exp_q[$];
    logic [3:0] col_q[$];

    always #5 clk = ~clk;

    keypad_scanner #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .row_n      (row_n),
        .inhibit    (inhibit),
        .col_n      (col_n),
        .key_pressed(key_pressed),
        .key_code   (key_code)
    );

    // Keypad: a closed key at (r,c) pulls row r low only while column c is driven low.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    task automatic wait_kp(input logic level, input int budget, output int cycles);
        cycles = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (key_pressed === level) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        inhibit = 1'b0;
        pressed = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (col_n !== 4'b1110) begin tests_failed++; $display("FAIL reset_col_n: got %b want 1110", col_n); end
        tests_run++;
        if (key_pressed !== 1'b0) begin tests_failed++; $display("FAIL reset_key_pressed: got %b want 0", key_pressed); end
        tests_run++;
        if (key_code !== 4'd0) begin tests_failed++; $display("FAIL reset_key_code: got %0d want 0", key_code); end
        rst = 1'b0;
    endtask

    task automatic test_idle_scan();
        logic [3:0] prev;
        logic [3:0] e;
        int cyc;
        int steps;
        bit kp_seen;
        col_q.push_back(4'b1101);
        col_q.push_back(4'b1011);
        col_q.push_back(4'b0111);
        col_q.push_back(4'b1110);
        prev = col_n; cyc = 0; steps = 0; kp_seen = 1'b0;
        for (int i = 0; i < 60 && steps < 4; i++) begin
            @(negedge clk);
            cyc++;
            if (key_pressed !== 1'b0) kp_seen = 1'b1;
            if (col_n !== prev) begin
                e = col_q.pop_front();
                tests_run++;
                if (col_n !== e) begin tests_failed++; $display("FAIL idle_col_step%0d: got %b want %b", steps, col_n, e); end
                tests_run++;
                if (cyc != PERIOD_CLKS) begin tests_failed++; $display("FAIL idle_step_period%0d: got %0d want %0d", steps, cyc, PERIOD_CLKS); end
                prev = col_n; cyc = 0; steps++;
            end
        end
        tests_run++;
        if (steps != 4) begin tests_failed++; $display("FAIL idle_steps: got %0d want 4", steps); end
        tests_run++;
        if (kp_seen) begin tests_failed++; $display("FAIL idle_key_pressed: got 1 want 0"); end
    endtask

    task automatic test_single_key();
        logic [3:0] e;
        int cyc;
        pressed[9] = 1'b1;
        exp_q.push_back(4'd9);
        wait_kp(1'b1, 60, cyc);
        e = exp_q.pop_front();
        tests_run++;
        if (cyc < 0) begin
            tests_failed++; $display("FAIL single_timeout: got no key_pressed want 1 within 60 clocks");
        end else begin
            tests_run++;
            if (key_code !== e) begin tests_failed++; $display("FAIL single_code: got %0d want %0d", key_code, e); end
            tests_run++;
            if (col_n !== 4'b1101) begin tests_failed++; $display("FAIL single_col: got %b want 1101", col_n); end
        end
        repeat (2 * PERIOD_CLKS) @(negedge clk);
        tests_run++;
        if (col_n !== 4'b1101 || key_pressed !== 1'b1) begin
            tests_failed++; $display("FAIL single_hold: got col %b kp %b want 1101 1", col_n, key_pressed);
        end
    endtask

    task automatic test_release_no_inhibit();
        pressed[9] = 1'b0;
        repeat (SYNC_LAT) @(negedge clk);
        tests_run++;
        if (key_pressed !== 1'b1 || col_n !== 4'b1101) begin
            tests_failed++; $display("FAIL release_early: got kp %b col %b want 1 1101", key_pressed, col_n);
        end
        @(negedge clk);
        tests_run++;
        if (key_pressed !== 1'b0) begin tests_failed++; $display("FAIL release_kp: got %b want 0", key_pressed); end
        tests_run++;
        if (col_n !== 4'b1011) begin tests_failed++; $display("FAIL release_col: got %b want 1011", col_n); end
        tests_run++;
        if (key_code !== 4'd9) begin tests_failed++; $display("FAIL release_code_kept: got %0d want 9", key_code); end
    endtask

    task automatic test_release_inhibit();
        logic [3:0] e;
        int cyc;
        bit col_bad;
        bit kp_bad;
        pressed[9] = 1'b1;
        exp_q.push_back(4'd9);
        wait_kp(1'b1, 80, cyc);
        e = exp_q.pop_front();
        tests_run++;
        if (cyc < 0 || key_code !== e) begin
            tests_failed++; $display("FAIL inh_capture: got cyc %0d code %0d want code %0d", cyc, key_code, e);
        end
        inhibit    = 1'b1;
        pressed[9] = 1'b0;
        col_bad = 1'b0; kp_bad = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (col_n !== 4'b1101) col_bad = 1'b1;
            if (i >= SYNC_LAT + 1 && key_pressed !== 1'b0) kp_bad = 1'b1;
        end
        tests_run++;
        if (col_bad) begin tests_failed++; $display("FAIL inh_col_frozen: got moved want 1101"); end
        tests_run++;
        if (kp_bad) begin tests_failed++; $display("FAIL inh_kp_low: got 1 want 0"); end
        inhibit = 1'b0;
        @(negedge clk);
        tests_run++;
        if (col_n !== 4'b1011) begin tests_failed++; $display("FAIL inh_exit_col: got %b want 1011", col_n); end
        repeat (PERIOD_CLKS - 1) @(negedge clk);
        tests_run++;
        if (col_n !== 4'b1011) begin tests_failed++; $display("FAIL inh_restart_early: got %b want 1011", col_n); end
        @(negedge clk);
        tests_run++;
        if (col_n !== 4'b0111) begin tests_failed++; $display("FAIL inh_restart_step: got %b want 0111", col_n); end
    endtask

    task automatic test_async_reset();
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (col_n !== 4'b1110) begin tests_failed++; $display("FAIL areset_col: got %b want 1110", col_n); end
        tests_run++;
        if (key_code !== 4'd0) begin tests_failed++; $display("FAIL areset_code: got %0d want 0", key_code); end
        tests_run++;
        if (key_pressed !== 1'b0) begin tests_failed++; $display("FAIL areset_kp: got %b want 0", key_pressed); end
        @(negedge clk);
        rst = 1'b0;
        repeat (PERIOD_CLKS - 1) @(negedge clk);
        tests_run++;
        if (col_n !== 4'b1110) begin tests_failed++; $display("FAIL areset_restart_early: got %b want 1110", col_n); end
        @(negedge clk);
        tests_run++;
        if (col_n !== 4'b1101) begin tests_failed++; $display("FAIL areset_restart_step: got %b want 1101", col_n); end
    endtask

    task automatic test_two_keys();
        logic [3:0] e;
        int cyc;
        pressed[4]  = 1'b1;
        pressed[12] = 1'b1;
        exp_q.push_back(4'd4);
        wait_kp(1'b1, 60, cyc);
        e = exp_q.pop_front();
        tests_run++;
        if (cyc < 0 || key_code !== e) begin
            tests_failed++; $display("FAIL two_keys_code: got cyc %0d code %0d want code %0d", cyc, key_code, e);
        end
        tests_run++;
        if (col_n !== 4'b1110) begin tests_failed++; $display("FAIL two_keys_col: got %b want 1110", col_n); end
        pressed[0] = 1'b1;
        repeat (5) @(negedge clk);
        tests_run++;
        if (key_pressed !== 1'b1 || key_code !== 4'd4) begin
            tests_failed++; $display("FAIL hold_ignore_other: got kp %b code %0d want 1 4", key_pressed, key_code);
        end
        pressed[4]  = 1'b0;
        pressed[12] = 1'b0;
        wait_kp(1'b0, 10, cyc);
        tests_run++;
        if (cyc != SYNC_LAT + 1) begin tests_failed++; $display("FAIL two_keys_release_lat: got %0d want %0d", cyc, SYNC_LAT + 1); end
        exp_q.push_back(4'd0);
        wait_kp(1'b1, 60, cyc);
        e = exp_q.pop_front();
        tests_run++;
        if (cyc < 0 || key_code !== e || col_n !== 4'b1110) begin
            tests_failed++; $display("FAIL rescan_code: got cyc %0d code %0d col %b want code %0d col 1110", cyc, key_code, col_n, e);
        end
        pressed[0] = 1'b0;
        wait_kp(1'b0, 10, cyc);
        tests_run++;
        if (cyc < 0) begin tests_failed++; $display("FAIL rescan_release: got kp 1 want 0 within 10 clocks"); end
    endtask

    task automatic test_inhibit_idle();
        logic [3:0] c0;
        logic [3:0] e;
        int cyc;
        bit moved;
        repeat (3) @(negedge clk);
        c0 = col_n;
        inhibit = 1'b1;
        moved = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (col_n !== c0 || key_pressed !== 1'b0) moved = 1'b1;
        end
        tests_run++;
        if (moved) begin tests_failed++; $display("FAIL idle_inhibit_frozen: got col %b want %b", col_n, c0); end
        inhibit = 1'b0;
        e   = {c0[2:0], c0[3]};
        cyc = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (col_n !== c0) begin cyc = i; break; end
        end
        tests_run++;
        if (cyc != PERIOD_CLKS - 3 || col_n !== e) begin
            tests_failed++; $display("FAIL idle_inhibit_resume: got %0d clocks col %b want %0d clocks col %b", cyc, col_n, PERIOD_CLKS - 3, e);
        end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_single_key();
        test_release_no_inhibit();
        test_release_inhibit();
        test_async_reset();
        test_two_keys();
        test_inhibit_idle();
        tests_run++;
        if (exp_q.size() != 0) begin tests_failed++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion want finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
